idct_col_sched: RTL
===================

Name: idct_col_sched

Overview:
Sequencer for the serial column-IDCT stage. It accepts one block request (4x4 or 8x8) at a time and reads the transposed row-stage results from the transpose buffer in column order. It streams them into the column IDCT with the correct start/idct4 controls, then frames the serial column outputs into a residual stream with valid/last markers and a done pulse. It sits between the transpose buffer and the reconstruction adder.

Parameters:
WIDTH_X, 16, sample width of buffer data, column-IDCT input and output
PIPE_LAT, 10, cycles from a col_start sample to its matching col_y sample (column datapath latency, >=2)
ADDR_W, 6, transpose buffer address width (row*8+col)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
req_valid  input  1  block request
req_ready  output  1  high only in IDLE (and rst_n high)
req_size  input  1  0 = 4x4 block, 1 = 8x8 block; sampled on accept
mem_rd_en  output  1  transpose buffer read strobe
mem_rd_addr  output  ADDR_W  read address = row*8 + col
mem_rd_data  input  WIDTH_X  read data, valid 1 cycle after mem_rd_en
col_start  output  1  sample strobe to column IDCT
col_idct4  output  2  01 = 4-point, 10 = 8-point, 00 = idle
col_x  output  WIDTH_X  sample to column IDCT
col_y  input  WIDTH_X  serial column IDCT output
out_valid  output  1  residual sample valid
out_data  output  WIDTH_X  residual sample
out_last  output  1  final sample of block, coincident with out_valid
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after out_last

Behaviour:
- Reset values: all outputs 0, req_ready 0 while rst_n low; state IDLE; all counters and the delay line cleared.
- N = 4 if req_size=0, else 8. The block holds N*N samples.
- States:
  - IDLE -> FEED on req_valid & req_ready. req_size latched at that edge (cycle T).
  - FEED: mem_rd_en high for N*N consecutive cycles, T+1 .. T+N*N. Addresses walk column-major: col outer, row inner. For N=4, the sequence is 0,8,16,24,1,9,...,27. Row and col counters wrap at N-1. FEED -> DRAIN after the cycle issuing the final address (row=col=N-1).
  - DRAIN: no reads. Wait until the last output has been emitted. DRAIN -> DONE in the cycle out_last is asserted.
  - DONE: done=1 for exactly one cycle, then -> IDLE.
- col_start is mem_rd_en registered by 1 cycle. col_x = mem_rd_data, captured in the same register stage.
- col_idct4 = 01/10 per the latched size during FEED, DRAIN and DONE; 00 in IDLE.
- Output framing:
  - A PIPE_LAT-deep shift register carries col_start.
  - out_valid = delayed bit. out_data is col_y registered at that point, so out_valid and out_data are aligned.
  - First out_valid appears at cycle T+1+1+PIPE_LAT.
  - out_cnt counts valid outputs 0 .. N*N-1. out_last = out_valid & (out_cnt == N*N-1).
- Total latency from accept to done: N*N + PIPE_LAT + 2 cycles.
- req_valid while busy is ignored, not queued. Requester holds req_valid until it sees ready.
- Back-to-back requests: the next accept is possible in the cycle after done (IDLE). No overlap with the previous block.
- rst_n low in any state aborts the block. Delay line and counters are flushed, so no stray out_valid or done appears after reset.
- Output stream has no backpressure. The consumer must accept every out_valid cycle.

Optional Feature:
IDCT_COL_SCHED_CLIP_EN.
- Defined: out_data saturates to signed 9-bit residual range [-256, 255], sign-extended to WIDTH_X.
- Undefined: out_data = col_y unmodified.
- Timing and framing are identical in both builds.

Test Plan:
- Reset, then 4x4 request accepted at T -> mem_rd_addr = 0,8,16,24,1,...,27 at T+1..T+16; col_idct4 = 01; first out_valid at T+12 (PIPE_LAT=10); out_last at T+27; done at T+28.
- 8x8 request -> 64 reads, last address 63; exactly 64 out_valid; out_last on the 64th; done at T+76.
- req_valid held high through a 4x4 block -> second accept only in the cycle after done; no reads are issued while busy.
- rst_n low for 1 cycle mid-FEED (after 5 reads) -> state IDLE; out_valid, done and col_start stay 0 for the following 20 cycles.
- Model column IDCT as a PIPE_LAT delay of col_x, with buffer contents addr*3 -> out_data order 0,24,48,72,3,... for 4x4.
- CLIP_EN build, col_y = 300 and -1000 -> out_data = 255 and -256; without the macro -> 300 and -1000.

Source files
------------

// File: rtl/idct_col_sched.sv
// Column-IDCT sequencer: reads the transpose buffer column-major, drives the serial column IDCT, frames the residual stream.
// Optional build macro IDCT_COL_SCHED_CLIP_EN saturates out_data to the signed 9-bit residual range.
module idct_col_sched #(
    parameter int WIDTH_X  = 16,
    parameter int PIPE_LAT = 10,
    parameter int ADDR_W   = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_size,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    input  logic [WIDTH_X-1:0] mem_rd_data,
    output logic               col_start,
    output logic [1:0]         col_idct4,
    output logic [WIDTH_X-1:0] col_x,
    input  logic [WIDTH_X-1:0] col_y,
    output logic               out_valid,
    output logic [WIDTH_X-1:0] out_data,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FEED  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]          state_r;
    logic                size_r;
    logic [2:0]          row_r;
    logic [2:0]          col_r;
    logic                rd_en_r;
    logic [ADDR_W-1:0]   rd_addr_r;
    logic [1:0]          idct4_r;
    logic                done_r;
    logic                col_start_r;
    logic [PIPE_LAT-1:0] dly_r;
    logic [5:0]          out_cnt_r;

    logic [2:0]          last_idx_s;
    logic [5:0]          last_cnt_s;
    logic                feed_last_s;
    logic [2:0]          row_nxt_s;
    logic [2:0]          col_nxt_s;
    logic                out_valid_s;
    logic                out_last_s;
    logic [WIDTH_X-1:0]  resid_s;

`ifdef IDCT_COL_SCHED_CLIP_EN
    localparam logic signed [WIDTH_X-1:0] RES_MAX = WIDTH_X'(255);
    localparam logic signed [WIDTH_X-1:0] RES_MIN = WIDTH_X'(-256);

    function automatic logic [WIDTH_X-1:0] sat9(input logic [WIDTH_X-1:0] v);
        logic signed [WIDTH_X-1:0] sv;
        sv = $signed(v);
        if (sv > RES_MAX) begin
            sat9 = RES_MAX;
        end else if (sv < RES_MIN) begin
            sat9 = RES_MIN;
        end else begin
            sat9 = v;
        end
    endfunction
`endif

    // Block geometry, read-walk successor and output framing decode
    always_comb begin
        last_idx_s  = size_r ? 3'd7 : 3'd3;
        last_cnt_s  = size_r ? 6'd63 : 6'd15;
        feed_last_s = (row_r == last_idx_s) && (col_r == last_idx_s);
        row_nxt_s   = row_r + 3'd1;
        col_nxt_s   = col_r;
        if (row_r == last_idx_s) begin
            row_nxt_s = 3'd0;
            col_nxt_s = col_r + 3'd1;
        end else begin
            row_nxt_s = row_r + 3'd1;
            col_nxt_s = col_r;
        end
        out_valid_s = dly_r[PIPE_LAT-1];
        out_last_s  = out_valid_s && (out_cnt_r == last_cnt_s);
    end

    // Residual value: saturated or passed through depending on build
    always_comb begin
`ifdef IDCT_COL_SCHED_CLIP_EN
        resid_s = sat9(col_y);
`else
        resid_s = col_y;
`endif
    end

    // Control FSM and read address generation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            size_r    <= 1'b0;
            row_r     <= 3'd0;
            col_r     <= 3'd0;
            rd_en_r   <= 1'b0;
            rd_addr_r <= {ADDR_W{1'b0}};
            idct4_r   <= 2'b00;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (req_valid) begin
                        state_r   <= ST_FEED;
                        size_r    <= req_size;
                        idct4_r   <= req_size ? 2'b10 : 2'b01;
                        rd_en_r   <= 1'b1;
                        row_r     <= 3'd0;
                        col_r     <= 3'd0;
                        rd_addr_r <= {ADDR_W{1'b0}};
                    end else begin
                        idct4_r <= 2'b00;
                    end
                end
                ST_FEED: begin
                    if (feed_last_s) begin
                        rd_en_r <= 1'b0;
                        state_r <= ST_DRAIN;
                    end else begin
                        row_r     <= row_nxt_s;
                        col_r     <= col_nxt_s;
                        rd_addr_r <= ADDR_W'({row_nxt_s, col_nxt_s});
                    end
                end
                ST_DRAIN: begin
                    if (out_last_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    idct4_r <= 2'b00;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    rd_en_r <= 1'b0;
                    idct4_r <= 2'b00;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Sample strobe stage, column-latency delay line and output counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_start_r <= 1'b0;
            dly_r       <= {PIPE_LAT{1'b0}};
            out_cnt_r   <= 6'd0;
        end else begin
            col_start_r <= rd_en_r;
            dly_r       <= {dly_r[PIPE_LAT-2:0], col_start_r};
            if (out_last_s) begin
                out_cnt_r <= 6'd0;
            end else if (out_valid_s) begin
                out_cnt_r <= out_cnt_r + 6'd1;
            end else begin
                out_cnt_r <= out_cnt_r;
            end
        end
    end

    // The buffer's read register is the stage aligned with col_start, so the sample passes straight through
    assign col_x       = col_start_r ? mem_rd_data : {WIDTH_X{1'b0}};
    assign col_start   = col_start_r;
    assign col_idct4   = idct4_r;
    assign mem_rd_en   = rd_en_r;
    assign mem_rd_addr = rd_addr_r;
    assign out_valid   = out_valid_s;
    assign out_last    = out_last_s;
    assign out_data    = out_valid_s ? resid_s : {WIDTH_X{1'b0}};
    assign done        = done_r;
    assign busy        = (state_r != ST_IDLE);
    assign req_ready   = rst_n && (state_r == ST_IDLE);

endmodule
